avg_arbiter: RTL
================

AVG_ARBITER -- requirements
Module: avg_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-005 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands, unsigned.
REQ-006 Port: req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same widths and meaning as requester 0.
REQ-008 Port: rsp_valid  output  1  response available.
REQ-009 Port: rsp_ready  input  1  consumer takes the response.
REQ-010 Port: rsp_id  output  1  requester that owns the response (0 or 1).
REQ-011 Port: rsp_result  output  WIDTH  floor((a+b)/2).
REQ-012 Port: served_cnt  output  8  count of completed responses.

Function
REQ-013 FSM states: IDLE, CALC, RESP; reset state IDLE.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert only its reqN_ready combinationally, capture a, b and id, go to CALC; otherwise stay in IDLE.
REQ-015 reqN_ready is 0 in CALC and RESP, and 0 for the non-granted requester.
REQ-016 Arbitration: round-robin with a 1-bit last_grant pointer; if both are valid, the requester not equal to last_grant wins; a lone valid requester always wins; the pointer updates on every grant.
REQ-017 last_grant resets to 1, so requester 0 wins the first simultaneous request.
REQ-018 CALC: compute the sum at WIDTH+1 bits (carry preserved), shift right 1, register the low WIDTH bits into rsp_result, go to RESP.
REQ-019 Truncating the sum to WIDTH before the shift is forbidden; 10+7 at WIDTH=4 gives 8, not 0.
REQ-020 RESP: rsp_valid=1, with rsp_id and rsp_result stable until rsp_valid&&rsp_ready; on that handshake, go to IDLE and increment served_cnt.
REQ-021 Latency: a grant in cycle N gives rsp_valid=1 in cycle N+2; with rsp_ready held high, the next grant is possible in cycle N+3.
REQ-022 served_cnt wraps from 255 to 0 with no flag.
REQ-023 Requester inputs are ignored outside IDLE; a requester holding valid is served on the next IDLE visit.
REQ-024 rsp_valid is never asserted in IDLE or CALC.

Reset
REQ-025 While rst_n=0: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, served_cnt=0, last_grant=1, req0_ready=req1_ready=0.
REQ-026 Asserting reset in CALC or RESP abandons the transaction; no response is produced for it after release.
REQ-027 The first grant is possible in the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package avg_pkg holds the FSM state enum, the default WIDTH constant, and the served_cnt width constant (8).
REQ-029 One sub-module, avg_core: purely combinational, WIDTH-parameterised, (a,b) -> (a+b)>>1 with a WIDTH+1 intermediate; instantiated once.
REQ-030 Registers live only in avg_arbiter.

Verification
REQ-031 req0 10,7 alone -> req0_ready in the grant cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_result=8; served_cnt=1 after the handshake.
REQ-032 req1 15,15 alone -> rsp_result=15, rsp_id=1 (carry-preserving max case); 0,1 -> 0.
REQ-033 Both valid from reset with held pairs -> responses in order id 0, 1, 0, 1 across four transactions.
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result held constant, reqN_ready=0 throughout, served_cnt unchanged.
REQ-035 rst_n pulsed low during CALC -> all outputs at reset values; after release, no stale response and req0 wins the next tie.
REQ-036 256 back-to-back transactions -> served_cnt reads 0 after the 256th handshake.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and constants for the averaging arbiter.
package avg_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/avg_core.sv
// Combinational floor((a+b)/2); the sum keeps its carry so max operands average correctly.
module avg_core
  import avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] avg
);
  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign avg = WIDTH'(sum >> 1);
endmodule

// File: rtl/avg_arbiter.sv
// Two-requester round-robin arbiter feeding one averaging unit; grant-to-response is 2 cycles.
// Requesters are stalled outside IDLE; a held response waits for rsp_ready with stable payload.
module avg_arbiter
  import avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [CNT_W-1:0] served_cnt
);
  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_any;
  logic             grant_id;
  logic             grant;
  logic             handshake;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] avg;

  avg_core #(.WIDTH(WIDTH)) u_core (
    .a   (a_q),
    .b   (b_q),
    .avg (avg)
  );

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by rst_n so nothing looks accepted while held in reset.
        req0_ready = rst_n & req0_valid & ~grant_id;
        req1_ready = rst_n & req1_valid & grant_id;
        grant      = grant_any;
        if (grant_any) state_nxt = CALC;
      end
      CALC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      served_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        a_q        <= grant_id ? req1_a : req0_a;
        b_q        <= grant_id ? req1_b : req0_b;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == CALC) rsp_result <= avg;
      if (handshake) served_cnt <= served_cnt + 1'b1;
    end
  end
endmodule
